// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : parametrised ALU with split operand arrival, operand timeout,
//            two-cycle multiply stage and a one-cycle result strobe.
// Revision : 1.0
// ============================================================================
module alu_pipe #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ce,
   input  logic [1:0]         inp_valid,
   input  logic               mode,
   input  logic [3:0]         cmd,
   input  logic               cin,
   input  logic [WIDTH-1:0]   opa,
   input  logic [WIDTH-1:0]   opb,
   output logic [2*WIDTH-1:0] res,
   output logic               cout,
   output logic               oflow,
   output logic               g,
   output logic               l,
   output logic               e,
   output logic               err,
   output logic               out_valid,
   output logic               busy
);

   localparam int c_SHW   = $clog2(WIDTH);
   localparam int c_CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
   localparam logic [WIDTH:0]     c_ONE      = {{WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_MUL  = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_mode;
   logic [3:0]           r_cmd;
   logic                 r_cin;
   logic                 r_have_a;
   logic [WIDTH-1:0]     r_opa;
   logic [WIDTH-1:0]     r_opb;
   logic [2*WIDTH-1:0]   r_res;
   logic                 r_cout;
   logic                 r_oflow;
   logic                 r_g;
   logic                 r_l;
   logic                 r_e;
   logic                 r_err;
   logic                 r_out_valid;
   logic                 r_busy;

   // Operation context: bus in IDLE, latched command plus merged operands in WAIT
   logic                 w_x_mode;
   logic [3:0]           w_x_cmd;
   logic                 w_x_cin;
   logic [WIDTH-1:0]     w_a;
   logic [WIDTH-1:0]     w_b;

   always_comb begin
      if (r_state == S_WAIT) begin
         w_x_mode = r_mode;
         w_x_cmd  = r_cmd;
         w_x_cin  = r_cin;
         w_a      = r_have_a ? r_opa : opa;
         w_b      = r_have_a ? opb   : r_opb;
      end else begin
         w_x_mode = mode;
         w_x_cmd  = cmd;
         w_x_cin  = cin;
         w_a      = opa;
         w_b      = opb;
      end
   end

   logic w_legal;
   logic w_a_only;
   logic w_b_only;
   logic w_is_mul;

   assign w_legal  = w_x_mode ? (w_x_cmd <= 4'd12) : (w_x_cmd <= 4'd13);
   assign w_a_only = w_x_mode ? (w_x_cmd == 4'd4 || w_x_cmd == 4'd5)
                              : (w_x_cmd == 4'd6 || w_x_cmd == 4'd8 || w_x_cmd == 4'd9);
   assign w_b_only = w_x_mode ? (w_x_cmd == 4'd6 || w_x_cmd == 4'd7)
                              : (w_x_cmd == 4'd7 || w_x_cmd == 4'd10 || w_x_cmd == 4'd11);
   assign w_is_mul = w_x_mode && (w_x_cmd == 4'd9 || w_x_cmd == 4'd10);

   logic w_issue;
   logic w_fail;
   logic w_enter_wait;
   logic w_partner;

   assign w_partner = r_have_a ? inp_valid[1] : inp_valid[0];

   always_comb begin
      w_issue      = 1'b0;
      w_fail       = 1'b0;
      w_enter_wait = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (inp_valid != 2'b00) begin
               if (!w_legal)
                  w_fail = 1'b1;
               else if (w_a_only)
                  w_issue = inp_valid[0];
               else if (w_b_only)
                  w_issue = inp_valid[1];
               else if (inp_valid == 2'b11)
                  w_issue = 1'b1;
               else
                  w_enter_wait = 1'b1;
            end
         end
         S_WAIT: begin
            if (w_partner)
               w_issue = 1'b1;
            else if (r_cnt == c_CNT_LAST)
               w_fail = 1'b1;
         end
         default: ;
      endcase
   end

   logic [WIDTH:0]       w_ea;
   logic [WIDTH:0]       w_eb;
   logic [WIDTH:0]       w_ec;
   logic [WIDTH:0]       w_ext;
   logic [2*WIDTH-1:0]   w_rot;
   logic [c_SHW-1:0]     w_amt;
   logic                 w_rot_bad;
   logic [WIDTH-1:0]     w_res;
   logic                 w_cout;
   logic                 w_oflow;
   logic                 w_g;
   logic                 w_l;
   logic                 w_e;
   logic                 w_err;

   assign w_ea      = {1'b0, w_a};
   assign w_eb      = {1'b0, w_b};
   assign w_ec      = {{WIDTH{1'b0}}, w_x_cin};
   assign w_amt     = w_b[c_SHW-1:0];
   assign w_rot_bad = |w_b[WIDTH-1:c_SHW];

   always_comb begin
      w_ext   = '0;
      w_rot   = '0;
      w_res   = '0;
      w_cout  = 1'b0;
      w_oflow = 1'b0;
      w_g     = 1'b0;
      w_l     = 1'b0;
      w_e     = 1'b0;
      w_err   = 1'b0;
      if (w_x_mode) begin
         case (w_x_cmd)
            4'd0:  begin w_ext = w_ea + w_eb;        w_cout  = w_ext[WIDTH]; end
            4'd1:  begin w_ext = w_ea - w_eb;        w_oflow = w_ext[WIDTH]; end
            4'd2:  begin w_ext = w_ea + w_eb + w_ec; w_cout  = w_ext[WIDTH]; end
            4'd3:  begin w_ext = w_ea - w_eb - w_ec; w_oflow = w_ext[WIDTH]; end
            4'd4:  begin w_ext = w_ea + c_ONE;       w_cout  = w_ext[WIDTH]; end
            4'd5:  begin w_ext = w_ea - c_ONE;       w_oflow = w_ext[WIDTH]; end
            4'd6:  begin w_ext = w_eb + c_ONE;       w_cout  = w_ext[WIDTH]; end
            4'd7:  begin w_ext = w_eb - c_ONE;       w_oflow = w_ext[WIDTH]; end
            4'd8:  begin
               w_g = (w_a > w_b);
               w_l = (w_a < w_b);
               w_e = (w_a == w_b);
            end
            4'd11: begin
               w_ext   = w_ea + w_eb;
               w_oflow = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_ext[WIDTH-1] != w_a[WIDTH-1]);
            end
            4'd12: begin
               w_ext   = w_ea - w_eb;
               w_oflow = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_ext[WIDTH-1] != w_a[WIDTH-1]);
            end
            4'd9, 4'd10: ;
            default: w_err = 1'b1;
         endcase
         w_res = w_ext[WIDTH-1:0];
      end else begin
         case (w_x_cmd)
            4'd0:  w_res = w_a & w_b;
            4'd1:  w_res = ~(w_a & w_b);
            4'd2:  w_res = w_a | w_b;
            4'd3:  w_res = ~(w_a | w_b);
            4'd4:  w_res = w_a ^ w_b;
            4'd5:  w_res = ~(w_a ^ w_b);
            4'd6:  w_res = ~w_a;
            4'd7:  w_res = ~w_b;
            4'd8:  w_res = w_a >> 1;
            4'd9:  w_res = w_a << 1;
            4'd10: w_res = w_b >> 1;
            4'd11: w_res = w_b << 1;
            4'd12: begin
               if (w_rot_bad) begin
                  w_err = 1'b1;
               end else begin
                  w_rot = {w_a, w_a} << w_amt;
                  w_res = w_rot[2*WIDTH-1:WIDTH];
               end
            end
            4'd13: begin
               if (w_rot_bad) begin
                  w_err = 1'b1;
               end else begin
                  w_rot = {w_a, w_a} >> w_amt;
                  w_res = w_rot[WIDTH-1:0];
               end
            end
            default: w_err = 1'b1;
         endcase
      end
   end

   // Multiply stage works from registered operands; product truncated to 2*WIDTH
   logic [WIDTH:0]       w_ma;
   logic [WIDTH:0]       w_mb;
   logic [2*WIDTH-1:0]   w_prod;

   always_comb begin
      if (r_cmd == 4'd9) begin
         w_ma = {1'b0, r_opa} + c_ONE;
         w_mb = {1'b0, r_opb} + c_ONE;
      end else begin
         w_ma = {r_opa, 1'b0};
         w_mb = {1'b0, r_opb};
      end
   end

   assign w_prod = {{(WIDTH-1){1'b0}}, w_ma} * {{(WIDTH-1){1'b0}}, w_mb};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_mode      <= 1'b0;
         r_cmd       <= '0;
         r_cin       <= 1'b0;
         r_have_a    <= 1'b0;
         r_opa       <= '0;
         r_opb       <= '0;
         r_res       <= '0;
         r_cout      <= 1'b0;
         r_oflow     <= 1'b0;
         r_g         <= 1'b0;
         r_l         <= 1'b0;
         r_e         <= 1'b0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (ce) begin
            if (r_state == S_MUL) begin
               r_res       <= w_prod;
               r_cout      <= 1'b0;
               r_oflow     <= 1'b0;
               r_g         <= 1'b0;
               r_l         <= 1'b0;
               r_e         <= 1'b0;
               r_err       <= 1'b0;
               r_out_valid <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end else if (w_fail) begin
               r_res       <= '0;
               r_cout      <= 1'b0;
               r_oflow     <= 1'b0;
               r_g         <= 1'b0;
               r_l         <= 1'b0;
               r_e         <= 1'b0;
               r_err       <= 1'b1;
               r_out_valid <= 1'b1;
               r_cnt       <= '0;
               r_state     <= S_IDLE;
            end else if (w_issue && w_is_mul) begin
               r_opa   <= w_a;
               r_opb   <= w_b;
               r_cmd   <= w_x_cmd;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
               r_state <= S_MUL;
            end else if (w_issue) begin
               r_res       <= {{WIDTH{1'b0}}, w_res};
               r_cout      <= w_cout;
               r_oflow     <= w_oflow;
               r_g         <= w_g;
               r_l         <= w_l;
               r_e         <= w_e;
               r_err       <= w_err;
               r_out_valid <= 1'b1;
               r_cnt       <= '0;
               r_state     <= S_IDLE;
            end else if (w_enter_wait) begin
               r_mode   <= mode;
               r_cmd    <= cmd;
               r_cin    <= cin;
               r_have_a <= inp_valid[0];
               r_opa    <= opa;
               r_opb    <= opb;
               r_cnt    <= '0;
               r_state  <= S_WAIT;
            end else if (r_state == S_WAIT) begin
               r_cnt <= r_cnt + c_CNT_W'(1);
            end
         end
      end
   end

   assign res       = r_res;
   assign cout      = r_cout;
   assign oflow     = r_oflow;
   assign g         = r_g;
   assign l         = r_l;
   assign e         = r_e;
   assign err       = r_err;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe : directed vectors for alu_pipe (WIDTH=8, TIMEOUT=16) checked
//               against an integer-arithmetic model every cycle.
// Revision    : 1.0
// ============================================================================
module tb_alu_pipe;

   localparam int TOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce = 1'b1;
   logic [1:0]  inp_valid = 2'b00;
   logic        mode = 1'b1;
   logic [3:0]  cmd = 4'd0;
   logic        cin = 1'b0;
   logic [7:0]  opa = 8'h00;
   logic [7:0]  opb = 8'h00;
   logic [15:0] res;
   logic        cout, oflow, g, l, e, err, out_valid, busy;

   int n_checks = 0;
   int n_errors = 0;

   alu_pipe #(.WIDTH(8), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .inp_valid(inp_valid), .mode(mode),
      .cmd(cmd), .cin(cin), .opa(opa), .opb(opb), .res(res), .cout(cout),
      .oflow(oflow), .g(g), .l(l), .e(e), .err(err), .out_valid(out_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [15:0] res;
      logic cout, oflow, g, l, e, err;
   } out_t;

   function automatic int sx(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   function automatic out_t golden(input logic md, input logic [3:0] c, input logic ci,
                                   input int a, input int b);
      out_t o;
      int t;
      o = '0;
      t = 0;
      if (md) begin
         case (c)
            0:  begin t = a + b;              o.cout  = (t > 255); end
            1:  begin t = a - b;              o.oflow = (t < 0);   end
            2:  begin t = a + b + int'(ci);   o.cout  = (t > 255); end
            3:  begin t = a - b - int'(ci);   o.oflow = (t < 0);   end
            4:  begin t = a + 1;              o.cout  = (t > 255); end
            5:  begin t = a - 1;              o.oflow = (t < 0);   end
            6:  begin t = b + 1;              o.cout  = (t > 255); end
            7:  begin t = b - 1;              o.oflow = (t < 0);   end
            8:  begin o.g = (a > b); o.l = (a < b); o.e = (a == b); end
            11: begin t = sx(a) + sx(b);      o.oflow = (t > 127 || t < -128); end
            12: begin t = sx(a) - sx(b);      o.oflow = (t > 127 || t < -128); end
            default: ;
         endcase
         if (c == 9)
            o.res = 16'(((a + 1) * (b + 1)) & 65535);
         else if (c == 10)
            o.res = 16'((a * 2 * b) & 65535);
         else if (c > 12)
            o.err = 1'b1;
         else
            o.res = 16'(t & 255);
      end else begin
         case (c)
            0:  t = a & b;
            1:  t = 255 - (a & b);
            2:  t = a | b;
            3:  t = 255 - (a | b);
            4:  t = a ^ b;
            5:  t = 255 - (a ^ b);
            6:  t = 255 - a;
            7:  t = 255 - b;
            8:  t = a / 2;
            9:  t = (a * 2) & 255;
            10: t = b / 2;
            11: t = (b * 2) & 255;
            12: if (b > 7) o.err = 1'b1; else t = ((a << b) | (a >> (8 - b))) & 255;
            13: if (b > 7) o.err = 1'b1; else t = ((a >> b) | (a << (8 - b))) & 255;
            default: o.err = 1'b1;
         endcase
         o.res = 16'(t);
      end
      return o;
   endfunction

   // 0 illegal, 1 needs A only, 2 needs B only, 3 needs both
   function automatic int kind(input logic md, input logic [3:0] c);
      if (md) begin
         if (c > 12) return 0;
         if (c == 4 || c == 5) return 1;
         if (c == 6 || c == 7) return 2;
         return 3;
      end
      if (c > 13) return 0;
      if (c == 6 || c == 8 || c == 9) return 1;
      if (c == 7 || c == 10 || c == 11) return 2;
      return 3;
   endfunction

   out_t       xo = '0;
   out_t       m_pend = '0;
   bit         x_valid = 0, x_busy = 0;
   bit         m_wait = 0, m_have_a = 0, m_mul = 0;
   int         m_age = 0, m_a = 0, m_b = 0;
   logic       m_mode = 0, m_cin = 0;
   logic [3:0] m_cmd = 0;

   task automatic deliver(input logic md, input logic [3:0] c, input logic ci,
                          input int a, input int b);
      if (md && (c == 4'd9 || c == 4'd10)) begin
         m_pend = golden(md, c, ci, a, b);
         m_mul  = 1;
         x_busy = 1;
      end else begin
         xo      = golden(md, c, ci, a, b);
         x_valid = 1;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            xo = '0; x_valid = 0; x_busy = 0;
            m_wait = 0; m_mul = 0; m_age = 0;
         end else begin
            x_valid = 0;
            if (ce) begin
               if (m_mul) begin
                  xo = m_pend; x_valid = 1; x_busy = 0; m_mul = 0;
               end else if (m_wait) begin
                  if (m_have_a ? inp_valid[1] : inp_valid[0]) begin
                     m_wait = 0;
                     deliver(m_mode, m_cmd, m_cin, m_have_a ? m_a : int'(opa),
                             m_have_a ? int'(opb) : m_b);
                  end else begin
                     m_age++;
                     if (m_age == TOUT) begin
                        xo = '0; xo.err = 1'b1; x_valid = 1; m_wait = 0;
                     end
                  end
               end else if (inp_valid != 2'b00) begin
                  case (kind(mode, cmd))
                     0: deliver(mode, cmd, cin, int'(opa), int'(opb));
                     1: if (inp_valid[0]) deliver(mode, cmd, cin, int'(opa), int'(opb));
                     2: if (inp_valid[1]) deliver(mode, cmd, cin, int'(opa), int'(opb));
                     default: begin
                        if (inp_valid == 2'b11) begin
                           deliver(mode, cmd, cin, int'(opa), int'(opb));
                        end else begin
                           m_wait = 1; m_age = 0; m_have_a = inp_valid[0];
                           m_mode = mode; m_cmd = cmd; m_cin = cin;
                           m_a = int'(opa); m_b = int'(opb);
                        end
                     end
                  endcase
               end
            end
         end
      end
   end

   // Continuous comparison of every output against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("m_valid", out_valid, x_valid);
         chk("m_busy",  busy,      x_busy);
         chk("m_res",   res,       xo.res);
         chk("m_cout",  cout,      xo.cout);
         chk("m_oflow", oflow,     xo.oflow);
         chk("m_g",     g,         xo.g);
         chk("m_l",     l,         xo.l);
         chk("m_e",     e,         xo.e);
         chk("m_err",   err,       xo.err);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic c, input logic [1:0] iv, input logic md,
                      input logic [3:0] cm, input logic ci,
                      input logic [7:0] a, input logic [7:0] b);
      ce = c; inp_valid = iv; mode = md; cmd = cm; cin = ci; opa = a; opb = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b1, 2'b00, 1'b1, 4'd0, 1'b0, 8'h00, 8'h00);
   endtask

   logic [7:0] ta [5] = '{8'h00, 8'h80, 8'h7F, 8'hC3, 8'hFF};
   logic [7:0] tb [5] = '{8'h01, 8'h80, 8'h01, 8'h05, 8'hFF};

   initial begin
      @(negedge clk);
      idle(2);
      chk("rst_res", res, 16'h0000);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      rst_n = 1'b1;
      idle(1);

      // add with carry out
      cyc(1, 2'b11, 1, 4'd0, 0, 8'hFF, 8'h01);
      chk("add_res", res, 16'h0000);
      chk("add_cout", cout, 1'b1);
      chk("add_valid", out_valid, 1'b1);
      idle(1);
      chk("add_strobe_once", out_valid, 1'b0);
      chk("add_cout_hold", cout, 1'b1);

      // (A+1)*(B+1); inputs during BUSY are dropped
      cyc(1, 2'b11, 1, 4'd9, 0, 8'h0F, 8'h0F);
      chk("mul_busy", busy, 1'b1);
      chk("mul_novalid", out_valid, 1'b0);
      cyc(1, 2'b11, 1, 4'd0, 0, 8'h01, 8'h01);
      chk("mul_res", res, 16'h0100);
      chk("mul_valid", out_valid, 1'b1);
      chk("mul_busy_clr", busy, 1'b0);
      idle(1);
      chk("mul_drop_valid", out_valid, 1'b0);
      chk("mul_drop_res", res, 16'h0100);

      // rotate left and bad rotate amount
      cyc(1, 2'b11, 0, 4'd12, 0, 8'h81, 8'h01);
      chk("rol_res", res, 16'h0003);
      chk("rol_err", err, 1'b0);
      cyc(1, 2'b11, 0, 4'd12, 0, 8'h81, 8'h11);
      chk("rolbad_err", err, 1'b1);
      chk("rolbad_res", res, 16'h0000);

      // split arrival; bus command changes in WAIT ignored
      cyc(1, 2'b01, 1, 4'd0, 0, 8'h10, 8'hEE);
      chk("split_wait", out_valid, 1'b0);
      repeat (4) cyc(1, 2'b00, 0, 4'd5, 1, 8'h99, 8'h77);
      cyc(1, 2'b10, 0, 4'd3, 1, 8'h55, 8'h20);
      chk("split_res", res, 16'h0030);
      chk("split_err", err, 1'b0);
      chk("split_valid", out_valid, 1'b1);

      // timeout with CE low gaps
      cyc(1, 2'b01, 1, 4'd0, 0, 8'h33, 8'h00);
      for (int i = 1; i <= 15; i++) begin
         if (i == 6) repeat (3) begin
            cyc(0, 2'b00, 1, 4'd0, 0, 8'h00, 8'h00);
            chk("tout_celow", out_valid, 1'b0);
         end
         idle(1);
         chk("tout_early", err, 1'b0);
      end
      idle(1);
      chk("tout_err", err, 1'b1);
      chk("tout_valid", out_valid, 1'b1);
      chk("tout_res", res, 16'h0000);

      // partner on the timeout edge wins
      cyc(1, 2'b01, 1, 4'd1, 0, 8'h07, 8'h00);
      idle(15);
      cyc(1, 2'b10, 1, 4'd0, 0, 8'h00, 8'h02);
      chk("edge_res", res, 16'h0005);
      chk("edge_err", err, 1'b0);
      chk("edge_valid", out_valid, 1'b1);

      // reset while waiting for an operand
      cyc(1, 2'b01, 1, 4'd0, 0, 8'h44, 8'h00);
      #2 rst_n = 1'b0;
      #1 chk("rstw_res", res, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 2'b10, 1, 4'd0, 0, 8'h00, 8'h11);
      chk("rstw_novalid", out_valid, 1'b0);
      idle(2);
      chk("rstw_quiet", out_valid, 1'b0);
      cyc(1, 2'b01, 1, 4'd0, 0, 8'h01, 8'h00);
      chk("rstw_after", res, 16'h0012);

      // reset while multiplying
      cyc(1, 2'b11, 1, 4'd9, 0, 8'h02, 8'h03);
      chk("rstm_busy_pre", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("rstm_busy", busy, 1'b0);
      chk("rstm_res", res, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      chk("rstm_novalid", out_valid, 1'b0);
      chk("rstm_res_hold", res, 16'h0000);

      // illegal command, no operand wait
      cyc(1, 2'b01, 1, 4'd14, 0, 8'h12, 8'h34);
      chk("ill_err", err, 1'b1);
      chk("ill_valid", out_valid, 1'b1);
      idle(1);
      chk("ill_once", out_valid, 1'b0);

      // sweep of every command against the model
      for (int md = 0; md < 2; md++)
         for (int c = 0; c < 16; c++)
            for (int p = 0; p < 5; p++)
               cyc(1, 2'b11, md[0], c[3:0], p[0], ta[p], tb[p]);

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
